// File: rtl/tlc_param_ctrl_if.sv
// rtl/tlc_param_ctrl_if.sv - sensor/lamp bundle between the junction front-end and tlc_param_ctrl
//
// Purpose: groups every non-clock signal of the traffic-light controller.
// Ports (master = sensor front-end / lamp driver side, slave = controller):
//   density    [NUM_DIR*DENS_W]  thermometer queue sensors, approach i at [i*DENS_W +: DENS_W]
//   emerg      [NUM_DIR]         emergency-vehicle request per approach
//   red_run    [NUM_DIR]         stop-line crossing detector per approach
//   light      [3*NUM_DIR]       lamp per approach, red=100 yellow=010 green=001
//   camera                       red-light violation trigger
//   phase      [3]               IDLE=0 SELECT=1 GREEN=2 YELLOW=3 ALLRED=4 EMERG=5
//   active_dir [DIR_W]           approach currently served
interface tlc_param_ctrl_if #(
  parameter int NUM_DIR = 4,
  parameter int DENS_W  = 3
);
  localparam int DIR_W = ($clog2(NUM_DIR) < 1) ? 1 : $clog2(NUM_DIR);

  logic [NUM_DIR*DENS_W-1:0] density;
  logic [NUM_DIR-1:0]        emerg;
  logic [NUM_DIR-1:0]        red_run;
  logic [3*NUM_DIR-1:0]      light;
  logic                      camera;
  logic [2:0]                phase;
  logic [DIR_W-1:0]          active_dir;

  modport master (
    output density, emerg, red_run,
    input  light, camera, phase, active_dir
  );

  modport slave (
    input  density, emerg, red_run,
    output light, camera, phase, active_dir
  );
endinterface

// File: rtl/tlc_param_ctrl.sv
// rtl/tlc_param_ctrl.sv - density-sized N-approach traffic-light controller with preemption and camera
//
// Purpose: serves the most congested approach, sizing green from its queue
// density, with anti-starvation skip counters, emergency preemption and a
// registered red-light camera trigger.
// Ports:
//   clock  system clock, all state on the rising edge
//   clear  synchronous active-high reset
//   bus    tlc_param_ctrl_if.slave (density/emerg/red_run in, light/camera/phase/active_dir out)
module tlc_param_ctrl #(
  parameter int NUM_DIR       = 4,
  parameter int DENS_W        = 3,
  parameter int TMR_W         = 8,
  parameter int MIN_GREEN     = 4,
  parameter int GREEN_PER_LVL = 4,
  parameter int YELLOW_T      = 3,
  parameter int ALLRED_T      = 1,
  parameter int MAX_SKIP      = 3
) (
  input  logic             clock,
  input  logic             clear,
  tlc_param_ctrl_if.slave  bus
);
  localparam int DIR_W  = ($clog2(NUM_DIR) < 1) ? 1 : $clog2(NUM_DIR);
  localparam int LVL_W  = $clog2(DENS_W + 1);
  localparam int SKIP_W = $clog2(MAX_SKIP + 1);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [TMR_W-1:0] YEL_LAST  = TMR_W'(YELLOW_T - 1);
  localparam logic [TMR_W-1:0] RED_LAST  = TMR_W'(ALLRED_T - 1);
  localparam logic [TMR_W-1:0] MING_LAST = TMR_W'(MIN_GREEN - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    GREEN  = 3'd2,
    YELLOW = 3'd3,
    ALLRED = 3'd4,
    EMERG  = 3'd5
  } phase_t;

  phase_t               state;
  logic [DIR_W-1:0]     dir;
  logic [TMR_W-1:0]     green_len;
  logic [TMR_W-1:0]     elapsed;
  logic [SKIP_W-1:0]    skip_cnt [NUM_DIR];
  logic [3*NUM_DIR-1:0] light;
  logic                 camera;

  // Level = run of ones from the nearest sensor; a gap ends the queue.
  function automatic logic [LVL_W-1:0] level_of(input logic [DENS_W-1:0] d);
    logic run;
    level_of = '0;
    run      = 1'b1;
    for (int b = 0; b < DENS_W; b++) begin
      run = run & d[b];
      if (run) level_of = level_of + LVL_W'(1);
    end
  endfunction

  function automatic logic [3*NUM_DIR-1:0] lamps(input logic [2:0] col, input logic [DIR_W-1:0] d);
    for (int i = 0; i < NUM_DIR; i++)
      lamps[3*i +: 3] = (DIR_W'(i) == d) ? col : RED;
  endfunction

  logic [LVL_W-1:0] lvl [NUM_DIR];
  logic [NUM_DIR-1:0] demand;
  logic [NUM_DIR-1:0] green_mask;
  logic [DIR_W-1:0]   emerg_low;
  logic [DIR_W-1:0]   starve_idx;
  logic               starve_any;
  logic [DIR_W-1:0]   best_idx;
  logic [LVL_W-1:0]   best_lvl;
  logic [DIR_W-1:0]   winner;
  logic               full_other;
  logic [TMR_W-1:0]   next_len;

  always_comb begin
    emerg_low  = '0;
    starve_idx = '0;
    starve_any = 1'b0;
    best_idx   = '0;
    best_lvl   = '0;
    full_other = 1'b0;
    for (int i = 0; i < NUM_DIR; i++) begin
      lvl[i]        = level_of(bus.density[i*DENS_W +: DENS_W]);
      demand[i]     = (lvl[i] != '0);
      green_mask[i] = light[3*i];
    end
    // Descending scans leave the lowest qualifying index in place.
    for (int i = NUM_DIR - 1; i >= 0; i--) begin
      if (bus.emerg[i]) emerg_low = DIR_W'(i);
      if (demand[i] && skip_cnt[i] >= SKIP_W'(MAX_SKIP)) begin
        starve_any = 1'b1;
        starve_idx = DIR_W'(i);
      end
    end
    // Strict compare keeps the lowest index on a level tie.
    for (int i = 0; i < NUM_DIR; i++) begin
      if (lvl[i] > best_lvl) begin
        best_lvl = lvl[i];
        best_idx = DIR_W'(i);
      end
      if (DIR_W'(i) != dir && lvl[i] == LVL_W'(DENS_W)) full_other = 1'b1;
    end
    winner   = starve_any ? starve_idx : best_idx;
    next_len = TMR_W'(MIN_GREEN) + TMR_W'(GREEN_PER_LVL) * (TMR_W'(lvl[winner]) - TMR_W'(1));
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= IDLE;
      dir       <= '0;
      green_len <= '0;
      elapsed   <= '0;
      light     <= {NUM_DIR{RED}};
      camera    <= 1'b0;
      for (int i = 0; i < NUM_DIR; i++) skip_cnt[i] <= '0;
    end else begin
      camera <= |(bus.red_run & ~green_mask);
      case (state)
        IDLE, SELECT: begin
          if (|bus.emerg) begin
            state <= EMERG;
            dir   <= emerg_low;
            light <= lamps(GRN, emerg_low);
          end else if (state == IDLE) begin
            if (|demand) state <= SELECT;
          end else if (|demand) begin
            for (int i = 0; i < NUM_DIR; i++) begin
              if (demand[i]) begin
                if (DIR_W'(i) == winner)                 skip_cnt[i] <= '0;
                else if (skip_cnt[i] < SKIP_W'(MAX_SKIP)) skip_cnt[i] <= skip_cnt[i] + SKIP_W'(1);
              end
            end
            dir       <= winner;
            green_len <= next_len;
            elapsed   <= '0;
            state     <= GREEN;
            light     <= lamps(GRN, winner);
          end else begin
            // Demand vanished during the selection cycle.
            state <= IDLE;
          end
        end
        GREEN: begin
          if (bus.emerg[dir]) begin
            state <= EMERG;
          end else if ((|bus.emerg) || elapsed == green_len - TMR_W'(1) ||
                       (elapsed >= MING_LAST && (lvl[dir] == '0 || full_other))) begin
            state   <= YELLOW;
            elapsed <= '0;
            light   <= lamps(YEL, dir);
          end else begin
            elapsed <= elapsed + TMR_W'(1);
          end
        end
        YELLOW: begin
          if (elapsed == YEL_LAST) begin
            state   <= ALLRED;
            elapsed <= '0;
            light   <= {NUM_DIR{RED}};
          end else begin
            elapsed <= elapsed + TMR_W'(1);
          end
        end
        ALLRED: begin
          if (elapsed == RED_LAST) begin
            state   <= IDLE;
            elapsed <= '0;
          end else begin
            elapsed <= elapsed + TMR_W'(1);
          end
        end
        EMERG: begin
          if (!bus.emerg[dir]) begin
            state   <= YELLOW;
            elapsed <= '0;
            light   <= lamps(YEL, dir);
          end
        end
        default: begin
          state <= IDLE;
          light <= {NUM_DIR{RED}};
        end
      endcase
    end
  end

  assign bus.phase      = state;
  assign bus.light      = light;
  assign bus.camera     = camera;
  assign bus.active_dir = dir;
endmodule

// File: tb/tb_tlc_param_ctrl.sv
// tb/tb_tlc_param_ctrl.sv - scoreboard bench for tlc_param_ctrl with a behavioural junction model
module tb_tlc_param_ctrl;
  localparam int ND = 4, DW = 3, MING = 4, GPL = 4, YT = 3, AT = 1, MS = 3, DIRW = 2;
  localparam int P_IDLE = 0, P_SEL = 1, P_GRN = 2, P_YEL = 3, P_RED = 4, P_EM = 5;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  tlc_param_ctrl_if #(.NUM_DIR(ND), .DENS_W(DW)) bus ();

  tlc_param_ctrl #(
    .NUM_DIR(ND), .DENS_W(DW), .TMR_W(8), .MIN_GREEN(MING), .GREEN_PER_LVL(GPL),
    .YELLOW_T(YT), .ALLRED_T(AT), .MAX_SKIP(MS)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus(bus)
  );

  typedef struct {
    int              phase;
    logic [3*ND-1:0] light;
    bit              cam;
    int              dir;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  bit   have_pend = 0;
  int   checks = 0;
  int   failures = 0;
  int   cyc_no = 0;
  int   g2 = 0;

  int m_phase = 0, m_dir = 0, m_len = 0, m_el = 0;
  int m_skip[ND];
  bit m_cam = 0;

  function automatic int lvl_of(logic [ND*DW-1:0] d, int i);
    int n = 0;
    while (n < DW && d[i*DW + n]) n++;
    return n;
  endfunction

  task automatic model_step(bit clr, logic [ND*DW-1:0] d, logic [ND-1:0] em, logic [ND-1:0] rr);
    int lv[ND];
    int low_em, win, best;
    bit any_dem, grn_now, full_other;
    if (clr) begin
      m_phase = P_IDLE; m_dir = 0; m_len = 0; m_el = 0; m_cam = 0;
      for (int i = 0; i < ND; i++) m_skip[i] = 0;
    end else begin
      grn_now = (m_phase == P_GRN || m_phase == P_EM);
      m_cam = 0;
      for (int i = 0; i < ND; i++)
        if (rr[i] && !(grn_now && i == m_dir)) m_cam = 1;
      any_dem = 0; low_em = -1; full_other = 0;
      for (int i = 0; i < ND; i++) begin
        lv[i] = lvl_of(d, i);
        if (lv[i] > 0) any_dem = 1;
        if (em[i] && low_em < 0) low_em = i;
        if (i != m_dir && lv[i] == DW) full_other = 1;
      end
      case (m_phase)
        P_IDLE: begin
          if (low_em >= 0) begin m_phase = P_EM; m_dir = low_em; end
          else if (any_dem) m_phase = P_SEL;
        end
        P_SEL: begin
          if (low_em >= 0) begin m_phase = P_EM; m_dir = low_em; end
          else if (!any_dem) m_phase = P_IDLE;
          else begin
            win = -1;
            for (int i = 0; i < ND; i++)
              if (win < 0 && lv[i] > 0 && m_skip[i] >= MS) win = i;
            if (win < 0) begin
              best = 0;
              for (int i = 0; i < ND; i++)
                if (lv[i] > best) begin best = lv[i]; win = i; end
            end
            for (int i = 0; i < ND; i++)
              if (lv[i] > 0) m_skip[i] = (i == win) ? 0 : ((m_skip[i] + 1 > MS) ? MS : m_skip[i] + 1);
            m_dir = win; m_len = MING + GPL * (lv[win] - 1); m_el = 0; m_phase = P_GRN;
          end
        end
        P_GRN: begin
          if (em[m_dir]) m_phase = P_EM;
          else if (low_em >= 0 || m_el == m_len - 1 ||
                   (m_el >= MING - 1 && (lv[m_dir] == 0 || full_other))) begin
            m_phase = P_YEL; m_el = 0;
          end else m_el++;
        end
        P_YEL: if (m_el == YT - 1) begin m_phase = P_RED; m_el = 0; end else m_el++;
        P_RED: if (m_el == AT - 1) begin m_phase = P_IDLE; m_el = 0; end else m_el++;
        P_EM:  if (!em[m_dir]) begin m_phase = P_YEL; m_el = 0; end
        default: m_phase = P_IDLE;
      endcase
    end
    pend.phase = m_phase;
    pend.dir   = m_dir;
    pend.cam   = m_cam;
    for (int i = 0; i < ND; i++) pend.light[3*i +: 3] = 3'b100;
    if (m_phase == P_GRN || m_phase == P_EM) pend.light[3*m_dir +: 3] = 3'b001;
    if (m_phase == P_YEL) pend.light[3*m_dir +: 3] = 3'b010;
  endtask

  task automatic cyc(bit clr, logic [ND*DW-1:0] d, logic [ND-1:0] em, logic [ND-1:0] rr);
    @(posedge clock);
    #1;
    if (have_pend) q.push_back(pend);
    clear = clr; bus.density = d; bus.emerg = em; bus.red_run = rr;
    model_step(clr, d, em, rr);
    have_pend = 1;
  endtask

  task automatic hold(logic [ND*DW-1:0] d, logic [ND-1:0] em, logic [ND-1:0] rr, int n);
    for (int k = 0; k < n; k++) cyc(0, d, em, rr);
  endtask

  // Runs until the model reaches phase ph (and elapsed el when el >= 0).
  task automatic wait_model(string name, logic [ND*DW-1:0] d, logic [ND-1:0] em, int ph, int el, int max);
    int k = 0;
    while (!(m_phase == ph && (el < 0 || m_el == el)) && k < max) begin
      cyc(0, d, em, '0);
      k++;
    end
    checks++;
    if (k >= max) begin
      failures++;
      $display("FAIL %s: phase %0d not reached within %0d cycles (model at %0d)", name, ph, max, m_phase);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      cyc_no++;
      if (bus.light[8:6] === 3'b001) g2++;
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (bus.phase !== 3'(e.phase) || bus.light !== e.light || bus.camera !== e.cam ||
            bus.active_dir !== DIRW'(e.dir)) begin
          failures++;
          $display("FAIL outputs @cycle %0d: got phase=%0d light=%b cam=%b dir=%0d, want phase=%0d light=%b cam=%b dir=%0d",
                   cyc_no, bus.phase, bus.light, bus.camera, bus.active_dir, e.phase, e.light, e.cam, e.dir);
        end
      end
    end
  end

  initial begin
    logic [ND*DW-1:0] d;
    logic [ND-1:0]    em;
    logic [ND-1:0]    rr;
    bus.density = '0; bus.emerg = '0; bus.red_run = '0;
    for (int i = 0; i < ND; i++) m_skip[i] = 0;

    repeat (3) cyc(1, '0, '0, '0);
    hold('0, '0, '0, 2);

    // Single demand on dir2 at level 2: select, 8 green, 3 yellow, 1 all-red.
    g2 = 0;
    hold(12'h0C0, '0, '0, 14);
    hold('0, '0, '0, 4);
    checks++;
    if (g2 != 8) begin
      failures++;
      $display("FAIL dir2_green_len: got %0d cycles, want 8", g2);
    end

    // Tie at full level between dir1 and dir3, then dir3 alone.
    hold(12'hE38, '0, '0, 30);
    hold(12'hE00, '0, '0, 20);
    hold('0, '0, '0, 4);

    // Emergency on another approach cuts dir0 green at elapsed 2.
    wait_model("emerg_setup", 12'h007, '0, P_GRN, 2, 20);
    hold(12'h007, 4'b1000, '0, 10);
    hold('0, '0, '0, 8);

    // Skip counter forces dir1 after three dir0 services.
    hold(12'h00F, '0, '0, 90);
    hold('0, '0, '0, 4);

    // Camera: green approach exempt, red and yellow approaches trigger.
    wait_model("camera_setup", 12'h003, '0, P_GRN, 0, 20);
    hold(12'h003, '0, 4'b0001, 2);
    hold(12'h003, '0, 4'b0010, 2);
    wait_model("camera_yellow", '0, '0, P_YEL, -1, 20);
    hold('0, '0, 4'b0001, 2);
    hold('0, '0, '0, 6);

    // Clear mid-GREEN and mid-EMERG.
    wait_model("clear_green", 12'h007, '0, P_GRN, 1, 20);
    cyc(1, 12'h007, '0, 4'b0010);
    hold('0, 4'b0100, '0, 3);
    wait_model("clear_emerg", '0, 4'b0100, P_EM, -1, 10);
    cyc(1, '0, 4'b0100, 4'b0001);
    hold('0, '0, '0, 4);

    // Randomised traffic.
    d = '0; em = '0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(7) == 0) begin
        for (int i = 0; i < ND; i++) begin
          if ($urandom_range(3) == 0) d[i*DW +: DW] = 3'($urandom);
          else d[i*DW +: DW] = 3'((1 << $urandom_range(DW)) - 1);
        end
      end
      if (em == '0 && $urandom_range(59) == 0) em = ND'(1 << $urandom_range(ND - 1));
      else if (em != '0 && $urandom_range(9) == 0) em = '0;
      else if (em != '0 && $urandom_range(19) == 0) em = em | ND'(1 << $urandom_range(ND - 1));
      rr = ($urandom_range(3) == 0) ? ND'($urandom) : '0;
      cyc($urandom_range(299) == 0, d, em, rr);
    end
    hold('0, '0, '0, 2);

    @(posedge clock);
    #1;
    if (have_pend) q.push_back(pend);
    have_pend = 0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
